// File: rtl/tf530_pkg.sv
// Shared definitions for the TF530 SRAM burst controller:
// state encoding, burst geometry and active-low signal levels.
package tf530_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      TERM = 2'd2,
      DONE = 2'd3
   } state_t;

   // 68030 cache line fill is four longwords
   localparam int BURST_LEN = 4;

   // wait-state counter width, enough for WS = 0..3
   localparam int WS_W = 2;

   // bus strobes on the 68030 side are active low
   localparam logic ASSERTED = 1'b0;
   localparam logic NEGATED  = 1'b1;

   // longword pointer advance inside a 16-byte line, 3 -> 0 wraps
   function automatic logic [1:0] wrap_inc(input logic [1:0] p);
      return p + 2'd1;
   endfunction

endpackage

// File: rtl/tf530_beat_timer.sv
// Wait-state down-counter for one SRAM beat. Loaded with WS-1 when a beat
// enters its wait phase; expire is high once the last wait clock is reached.
module tf530_beat_timer
   import tf530_pkg::*;
#(
   parameter int WS = 0
) (
   input  logic CLKCPU,
   input  logic RESET,
   input  logic load,
   input  logic dec,
   output logic expire
);

   // WS = 0 never enters the wait phase, so the load value is irrelevant there
   localparam logic [WS_W-1:0] LOAD_VAL = WS_W'((WS > 0) ? (WS - 1) : 0);

   logic [WS_W-1:0] cnt;

   // count down the remaining wait clocks of the current beat
   always_ff @(posedge CLKCPU or posedge RESET) begin
      if (RESET) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/tf530_burst_ctrl.sv
// 68030 on-board SRAM cycle sequencer. Runs single-beat and 4-longword
// burst-fill cycles with synchronous termination (STERM), burst acknowledge
// (CBACK), wrapping longword address (BA) and SRAM output enable (RAMOE).
module tf530_burst_ctrl
   import tf530_pkg::*;
#(
   parameter int WS       = 0,
   parameter int BURST_EN = 1
) (
   input  logic       CLKCPU,
   input  logic       RESET,
   input  logic       AS20,
   input  logic       RW20,
   input  logic       RAM_SEL,
   input  logic       CBREQ,
   input  logic [1:0] A32,
   output logic       STERM,
   output logic       CBACK,
   output logic [1:0] BA,
   output logic       RAMOE,
   output logic       BUSY
);

   // with no wait states every beat is a single TERM clock
   localparam state_t BEAT_ENTRY  = (WS == 0) ? TERM : WAIT;
   localparam logic   STERM_ENTRY = (WS == 0) ? ASSERTED : NEGATED;
   localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);
   localparam logic [1:0] PRE_LAST  = 2'(BURST_LEN - 2);

   state_t     state;
   logic       burst;
   logic [1:0] beat;
   logic [1:0] ptr;

   logic start;
   logic burst_req;
   logic more_beats;
   logic as_held;
   logic tmr_load;
   logic tmr_dec;
   logic tmr_expire;

   assign start      = (AS20 == ASSERTED) && (RAM_SEL == ASSERTED);
   // writes never burst; CBACK is only offered on reads
   assign burst_req  = (BURST_EN != 0) && (CBREQ == ASSERTED) && RW20;
   assign as_held    = (AS20 == ASSERTED);
   // CBREQ negated at the end of a TERM ends the burst after this beat
   assign more_beats = burst && (beat != LAST_BEAT) && (CBREQ == ASSERTED);

   assign tmr_load = ((state == IDLE) && start) ||
                     ((state == TERM) && as_held && more_beats);
   assign tmr_dec  = (state == WAIT);

   tf530_beat_timer #(
      .WS (WS)
   ) u_timer (
      .CLKCPU (CLKCPU),
      .RESET  (RESET),
      .load   (tmr_load),
      .dec    (tmr_dec),
      .expire (tmr_expire)
   );

   // cycle sequencer with registered bus outputs
   always_ff @(posedge CLKCPU or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         STERM <= NEGATED;
         CBACK <= NEGATED;
         RAMOE <= NEGATED;
         burst <= 1'b0;
         beat  <= 2'd0;
         ptr   <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ptr   <= A32;
                  beat  <= 2'd0;
                  burst <= burst_req;
                  state <= BEAT_ENTRY;
                  STERM <= STERM_ENTRY;
                  CBACK <= burst_req ? ASSERTED : NEGATED;
                  RAMOE <= ASSERTED;
               end
            end
            WAIT: begin
               if (!as_held) begin
                  // CPU withdrew the cycle before termination
                  state <= IDLE;
                  STERM <= NEGATED;
                  CBACK <= NEGATED;
                  RAMOE <= NEGATED;
               end else if (tmr_expire) begin
                  state <= TERM;
                  STERM <= ASSERTED;
               end
            end
            TERM: begin
               STERM <= NEGATED;
               if (!as_held) begin
                  state <= IDLE;
                  CBACK <= NEGATED;
                  RAMOE <= NEGATED;
               end else if (more_beats) begin
                  state <= BEAT_ENTRY;
                  beat  <= beat + 2'd1;
                  ptr   <= wrap_inc(ptr);
                  STERM <= STERM_ENTRY;
                  // CBACK drops for the final beat of the line
                  CBACK <= (beat == PRE_LAST) ? NEGATED : ASSERTED;
               end else begin
                  state <= DONE;
                  CBACK <= NEGATED;
                  RAMOE <= NEGATED;
               end
            end
            DONE: begin
               // hold until the strobe is released so one AS20 gives one cycle
               if (!as_held) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign BA   = (state == IDLE) ? A32 : ptr;
   assign BUSY = (state != IDLE);

endmodule
